// File: rtl/reg_seq_pkg.sv
// Shared types and constants for the reg_seq register-file sequencer.
// REG_SEQ_SAT_EN (when defined) selects saturating ADD/SUB in reg_seq_unit.
package reg_seq_pkg;

    typedef enum logic [2:0] {
        OpWr   = 3'd0,
        OpRd1  = 3'd1,
        OpRd2  = 3'd2,
        OpRd1w = 3'd3,
        OpRd2w = 3'd4,
        OpAdd  = 3'd5,
        OpSub  = 3'd6,
        OpShl  = 3'd7
    } op_e;

    typedef enum logic [2:0] {
        StIdle,
        StRead,
        StExec,
        StWrite,
        StResp
    } state_e;

    localparam int unsigned DATA_W_DEFAULT = 16;
    localparam int unsigned ADDR_W_DEFAULT = 5;
    localparam int unsigned DEPTH          = 2 ** ADDR_W_DEFAULT;
    localparam int unsigned SHAMT_W        = $clog2(DATA_W_DEFAULT);

    function automatic int unsigned depth_of(int unsigned addr_w);
        return 2 ** addr_w;
    endfunction

    function automatic int unsigned shamt_w_of(int unsigned data_w);
        return $clog2(data_w);
    endfunction

    // Only the two pure reads leave the register file untouched.
    function automatic logic op_writes(op_e op);
        return (op != OpRd1) && (op != OpRd2);
    endfunction

endpackage

// File: rtl/reg_seq_if.sv
// Request/response handshake bundle between a command source and reg_seq_unit.
interface reg_seq_if #(
    parameter int unsigned DATA_W = reg_seq_pkg::DATA_W_DEFAULT,
    parameter int unsigned ADDR_W = reg_seq_pkg::ADDR_W_DEFAULT
);

    logic               req_valid;
    logic               req_ready;
    reg_seq_pkg::op_e   req_op;
    logic [ADDR_W-1:0]  req_ra1;
    logic [ADDR_W-1:0]  req_ra2;
    logic [ADDR_W-1:0]  req_wa;
    logic [DATA_W-1:0]  req_wdata;
    logic               rsp_valid;
    logic               rsp_ready;
    logic [DATA_W-1:0]  rsp_data1;
    logic [DATA_W-1:0]  rsp_data2;
    logic               rsp_carry;

    modport master (
        output req_valid, req_op, req_ra1, req_ra2, req_wa, req_wdata, rsp_ready,
        input  req_ready, rsp_valid, rsp_data1, rsp_data2, rsp_carry
    );

    modport slave (
        input  req_valid, req_op, req_ra1, req_ra2, req_wa, req_wdata, rsp_ready,
        output req_ready, rsp_valid, rsp_data1, rsp_data2, rsp_carry
    );

endinterface

// File: rtl/reg_seq_regfile.sv
// DEPTH x DATA_W register file: two registered read ports, one write port,
// synchronous clear while rst_n is low (reset beats a coincident write).
module reg_seq_regfile #(
    parameter int unsigned DATA_W = reg_seq_pkg::DATA_W_DEFAULT,
    parameter int unsigned ADDR_W = reg_seq_pkg::ADDR_W_DEFAULT
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [ADDR_W-1:0] ra1,
    input  logic [ADDR_W-1:0] ra2,
    output logic [DATA_W-1:0] rd1,
    output logic [DATA_W-1:0] rd2,
    input  logic              we,
    input  logic [ADDR_W-1:0] wa,
    input  logic [DATA_W-1:0] wd
);

    localparam int unsigned DEPTH = reg_seq_pkg::depth_of(ADDR_W);

    logic [DATA_W-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
            rd1 <= '0;
            rd2 <= '0;
        end else begin
            if (we) begin
                mem[wa] <= wd;
            end
            rd1 <= mem[ra1];
            rd2 <= mem[ra2];
        end
    end

endmodule

// File: rtl/reg_seq_unit.sv
// Register-file sequencer: IDLE->READ->EXEC->WRITE->RESP for every command.
// Define REG_SEQ_SAT_EN for saturating ADD/SUB results.
module reg_seq_unit
    import reg_seq_pkg::*;
#(
    parameter int unsigned DATA_W = DATA_W_DEFAULT,
    parameter int unsigned ADDR_W = ADDR_W_DEFAULT
) (
    input  logic     clk,
    input  logic     rst_n,
    reg_seq_if.slave bus
);

    localparam int unsigned       SH_W      = shamt_w_of(DATA_W);
    localparam logic [DATA_W-1:0] SHL_LIMIT = DATA_W'(DATA_W);

    state_e            state_q;
    op_e               op_q;
    logic [ADDR_W-1:0] ra1_q, ra2_q, wa_q;
    logic [DATA_W-1:0] wdata_q;
    logic [DATA_W-1:0] rd1, rd2;
    logic [DATA_W-1:0] d1_c, d2_c, wval_c;
    logic [DATA_W-1:0] d1_q, d2_q, wval_q;
    logic              carry_c, carry_q;
    logic [DATA_W:0]   sum_c, diff_c;
    logic              we;
    logic              req_ready_q, rsp_valid_q, rsp_carry_q;
    logic [DATA_W-1:0] rsp_data1_q, rsp_data2_q;

    assign we = (state_q == StWrite) && op_writes(op_q);

    reg_seq_regfile #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W)
    ) u_regfile (
        .clk   (clk),
        .rst_n (rst_n),
        .ra1   (ra1_q),
        .ra2   (ra2_q),
        .rd1   (rd1),
        .rd2   (rd2),
        .we    (we),
        .wa    (wa_q),
        .wd    (wval_q)
    );

    // ALU and response shaping from the registered read data seen in EXEC.
    always_comb begin
        sum_c   = {1'b0, rd1} + {1'b0, rd2};
        diff_c  = {1'b0, rd1} - {1'b0, rd2};
        d1_c    = '0;
        d2_c    = '0;
        carry_c = 1'b0;
        wval_c  = wdata_q;
        unique case (op_q)
            OpWr: d1_c = wdata_q;
            OpRd1, OpRd1w: d1_c = rd1;
            OpRd2, OpRd2w: begin
                d1_c = rd1;
                d2_c = rd2;
            end
            OpAdd: begin
                carry_c = sum_c[DATA_W];
                d1_c    = sum_c[DATA_W-1:0];
`ifdef REG_SEQ_SAT_EN
                if (carry_c) d1_c = '1;
`endif
                d2_c    = rd2;
                wval_c  = d1_c;
            end
            OpSub: begin
                carry_c = diff_c[DATA_W];
                d1_c    = diff_c[DATA_W-1:0];
`ifdef REG_SEQ_SAT_EN
                if (carry_c) d1_c = '0;
`endif
                d2_c    = rd2;
                wval_c  = d1_c;
            end
            OpShl: begin
                d1_c   = (wdata_q >= SHL_LIMIT) ? '0 : (rd1 << wdata_q[SH_W-1:0]);
                d2_c   = wdata_q;
                wval_c = d1_c;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= StIdle;
            op_q        <= OpWr;
            ra1_q       <= '0;
            ra2_q       <= '0;
            wa_q        <= '0;
            wdata_q     <= '0;
            d1_q        <= '0;
            d2_q        <= '0;
            wval_q      <= '0;
            carry_q     <= 1'b0;
            req_ready_q <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_data1_q <= '0;
            rsp_data2_q <= '0;
            rsp_carry_q <= 1'b0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    req_ready_q <= 1'b1;
                    if (bus.req_valid && req_ready_q) begin
                        op_q        <= bus.req_op;
                        ra1_q       <= bus.req_ra1;
                        ra2_q       <= bus.req_ra2;
                        wa_q        <= bus.req_wa;
                        wdata_q     <= bus.req_wdata;
                        req_ready_q <= 1'b0;
                        state_q     <= StRead;
                    end
                end
                StRead: state_q <= StExec;
                StExec: begin
                    d1_q    <= d1_c;
                    d2_q    <= d2_c;
                    wval_q  <= wval_c;
                    carry_q <= carry_c;
                    state_q <= StWrite;
                end
                StWrite: begin
                    rsp_valid_q <= 1'b1;
                    rsp_data1_q <= d1_q;
                    rsp_data2_q <= d2_q;
                    rsp_carry_q <= carry_q;
                    state_q     <= StResp;
                end
                StResp: begin
                    if (bus.rsp_ready) begin
                        rsp_valid_q <= 1'b0;
                        req_ready_q <= 1'b1;
                        state_q     <= StIdle;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign bus.req_ready = req_ready_q;
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_data1 = rsp_data1_q;
    assign bus.rsp_data2 = rsp_data2_q;
    assign bus.rsp_carry = rsp_carry_q;

endmodule
